// File: rtl/calc_sequencer.sv
// calc_sequencer: token-driven controller for the 5-entry operand queue and 8-bit ALU.
// Latency: one queue command per token, issued the cycle after acceptance; a token is accepted every 3 cycles at best.
// Backpressure: tok_ready is low outside IDLE; a result waits in EMIT until res_ready.
// Ports: clk/rst (async, active-high) clock and reset
//        tok_valid/tok_ready/tok_is_op/tok_data   token stream in
//        res_valid/res_ready/res_data             final result out
//        err/err_clr/busy                         sticky error, its clear, and FSM activity
//        q_opcode/q_back                          command and data to the queue
//        q_top_conc/q_pos_back/q_is_err           front two entries, occupancy and error from the queue
module calc_sequencer #(
  parameter int W     = 8,
  parameter int DEPTH = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tok_valid,
  output logic           tok_ready,
  input  logic           tok_is_op,
  input  logic [W-1:0]   tok_data,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [W-1:0]   res_data,
  output logic           err,
  input  logic           err_clr,
  output logic           busy,
  output logic [1:0]     q_opcode,
  output logic [W-1:0]   q_back,
  input  logic [2*W-1:0] q_top_conc,
  input  logic [2:0]     q_pos_back,
  input  logic           q_is_err
);

  localparam logic [1:0] OP_PUSH   = 2'b00;
  localparam logic [1:0] OP_IDLE   = 2'b01;
  localparam logic [1:0] OP_REDUCE = 2'b10;
  localparam logic [1:0] OP_POP    = 2'b11;
  localparam logic [2:0] DEPTH_C   = 3'(DEPTH);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, ERROR} state_t;

  state_t         state_q;
  logic           res_valid_q;
  logic [W-1:0]   res_data_q;
  logic           err_q;
  logic [1:0]     q_opcode_q;
  logic [W-1:0]   q_back_q;

  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W-1:0]   alu_d;

  // Entry 0 (front) is the left operand, entry 1 the right one.
  assign op_a = q_top_conc[2*W-1:W];
  assign op_b = q_top_conc[W-1:0];

  // All results wrap modulo 2^W; the multiply keeps only the low W bits.
  always_comb begin
    alu_d = '0;
    case (tok_data[1:0])
      2'b00:   alu_d = op_a + op_b;
      2'b01:   alu_d = op_a - op_b;
      2'b10:   alu_d = op_a * op_b;
      default: alu_d = op_a & op_b;
    endcase
  end

  // A queue error seen in IDLE diverts to ERROR, so no token may be taken that cycle.
  assign tok_ready = (state_q == IDLE) && !rst && !q_is_err;
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign err       = err_q;
  assign q_opcode  = q_opcode_q;
  assign q_back    = q_back_q;

  // q_opcode_q doubles as the pending command: loaded on entry to ISSUE, cleared on exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
      q_opcode_q  <= OP_IDLE;
      q_back_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (q_is_err) begin
            state_q <= ERROR;
            err_q   <= 1'b1;
          end else if (tok_valid) begin
            if (!tok_is_op) begin
              if (q_pos_back == DEPTH_C) begin
                state_q <= ERROR;
                err_q   <= 1'b1;
              end else begin
                q_back_q   <= tok_data;
                q_opcode_q <= OP_PUSH;
                state_q    <= ISSUE;
              end
            end else if (!tok_data[2]) begin
              if (q_pos_back < 3'd2) begin
                state_q <= ERROR;
                err_q   <= 1'b1;
              end else begin
                q_back_q   <= alu_d;
                q_opcode_q <= OP_REDUCE;
                state_q    <= ISSUE;
              end
            end else begin
              // Finish is only meaningful with exactly one value left.
              if (q_pos_back != 3'd1) begin
                state_q <= ERROR;
                err_q   <= 1'b1;
              end else begin
                res_data_q  <= op_a;
                res_valid_q <= 1'b1;
                state_q     <= EMIT;
              end
            end
          end
        end
        ISSUE: begin
          q_opcode_q <= OP_IDLE;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (q_is_err) begin
            state_q <= ERROR;
            err_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        EMIT: begin
          // Once delivered, the result is popped so the queue ends empty.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            q_opcode_q  <= OP_POP;
            state_q     <= ISSUE;
          end
        end
        ERROR: begin
          if (err_clr) begin
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: drives calc_sequencer against a behavioural queue and a token-level reference model.
// Latency: checks the documented cycle timing of each token, result and error recovery.
// Backpressure: holds res_ready low for random stretches and waits (bounded) on tok_ready.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        tok_valid;
  logic        tok_ready;
  logic        tok_is_op;
  logic [7:0]  tok_data;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        err;
  logic        err_clr;
  logic        busy;
  logic [1:0]  q_opcode;
  logic [7:0]  q_back;
  logic [15:0] q_top_conc = '0;
  logic [2:0]  q_pos_back = '0;
  logic        q_is_err;

  calc_sequencer #(.W(8), .DEPTH(5)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op), .tok_data(tok_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err), .err_clr(err_clr), .busy(busy),
    .q_opcode(q_opcode), .q_back(q_back),
    .q_top_conc(q_top_conc), .q_pos_back(q_pos_back), .q_is_err(q_is_err)
  );

  always #5 clk = ~clk;

  // Behavioural operand queue: executes whatever command the controller issues.
  logic [7:0] emu_q[$];
  bit         emu_clr = 1'b0;
  bit         emu_bad = 1'b0;

  always @(posedge clk) begin
    if (emu_clr) emu_q.delete();
    else begin
      case (q_opcode)
        2'b00: if (emu_q.size() >= 5) emu_bad = 1'b1; else emu_q.push_back(q_back);
        2'b10: if (emu_q.size() < 2) emu_bad = 1'b1;
               else begin
                 void'(emu_q.pop_front());
                 void'(emu_q.pop_front());
                 emu_q.push_front(q_back);
               end
        2'b11: if (emu_q.size() == 0) emu_bad = 1'b1; else void'(emu_q.pop_front());
        default: ;
      endcase
    end
    q_pos_back <= 3'(emu_q.size());
    q_top_conc <= {(emu_q.size() > 0) ? emu_q[0] : 8'h00, (emu_q.size() > 1) ? emu_q[1] : 8'h00};
  end

  // Reference model state: what the queue should hold after each completed token.
  logic [7:0] ref_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_vec = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (op)
      2'd0:    r = ia + ib;
      2'd1:    r = ia - ib;
      2'd2:    r = ia * ib;
      default: r = ia & ib;
    endcase
    r = ((r % 256) + 256) % 256;
    return 8'(r);
  endfunction

  // kind: 0 push, 1 reduce, 2 finish. A successful finish leaves the DUT in EMIT.
  task automatic send_tok(input bit is_op, input logic [7:0] d,
                          output bit was_err, output int kind, output logic [7:0] val);
    int n, depth;
    n = 0;
    while (!tok_ready && n < 16) begin @(negedge clk); n++; end
    check("tok_ready_wait", 32'(tok_ready), 32'd1);
    depth = ref_q.size();
    val = 8'h00;
    if (!is_op) begin
      kind = 0; was_err = (depth == 5); val = d;
    end else if (!d[2]) begin
      kind = 1; was_err = (depth < 2);
      if (!was_err) val = alu(d[1:0], ref_q[0], ref_q[1]);
    end else begin
      kind = 2; was_err = (depth != 1);
      if (!was_err) val = ref_q[0];
    end
    tok_valid = 1'b1; tok_is_op = is_op; tok_data = d;
    @(negedge clk);
    tok_valid = 1'b0; tok_is_op = 1'($urandom); tok_data = 8'($urandom);
    n_vec++;
    if (was_err) begin
      check("err_set", 32'(err), 32'd1);
      check("err_tok_ready", 32'(tok_ready), 32'd0);
      check("err_qop", 32'(q_opcode), 32'd1);
      @(negedge clk);
      check("err_qop_hold", 32'(q_opcode), 32'd1);
      check("err_depth", 32'(q_pos_back), 32'(depth));
      if (depth > 0) check("err_front", 32'(q_top_conc[15:8]), 32'(ref_q[0]));
    end else if (kind == 2) begin
      check("fin_valid", 32'(res_valid), 32'd1);
      check("fin_data", 32'(res_data), 32'(val));
      check("fin_qop", 32'(q_opcode), 32'd1);
      check("fin_tok_ready", 32'(tok_ready), 32'd0);
    end else begin
      check("issue_qop", 32'(q_opcode), (kind == 0) ? 32'd0 : 32'd2);
      check("issue_q_back", 32'(q_back), 32'(val));
      check("issue_tok_ready", 32'(tok_ready), 32'd0);
      if (kind == 0) ref_q.push_back(d);
      else begin
        void'(ref_q.pop_front());
        void'(ref_q.pop_front());
        ref_q.push_front(val);
      end
      @(negedge clk);
      check("wait_qop", 32'(q_opcode), 32'd1);
      @(negedge clk);
      check("back_idle", 32'(busy), 32'd0);
      check("depth", 32'(q_pos_back), 32'(ref_q.size()));
      check("front", 32'(q_top_conc[15:8]), 32'(ref_q[0]));
    end
  endtask

  task automatic take_result(input logic [7:0] exp_v, input int hold);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data", 32'(res_data), 32'(exp_v));
      check("hold_qop", 32'(q_opcode), 32'd1);
      @(negedge clk);
    end
    check("res_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("res_drop", 32'(res_valid), 32'd0);
    check("pop_qop", 32'(q_opcode), 32'd3);
    void'(ref_q.pop_front());
    @(negedge clk);
    check("pop_wait_qop", 32'(q_opcode), 32'd1);
    @(negedge clk);
    check("pop_idle", 32'(busy), 32'd0);
    check("pop_depth", 32'(q_pos_back), 32'd0);
    check("pop_err", 32'(err), 32'd0);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("clr_err", 32'(err), 32'd0);
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_tok_ready", 32'(tok_ready), 32'd1);
  endtask

  task automatic flush();
    emu_clr = 1'b1;
    @(negedge clk);
    emu_clr = 1'b0;
    ref_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; tok_valid = 1'b0; tok_is_op = 1'b0; tok_data = '0;
    res_ready = 1'b0; err_clr = 1'b0; q_is_err = 1'b0; emu_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_tok_ready", 32'(tok_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_qop", 32'(q_opcode), 32'd1);
    check("rst_q_back", 32'(q_back), 32'd0);
    emu_clr = 1'b0;
    ref_q.delete();
    rst = 1'b0;
    #1;
    check("post_rst_tok_ready", 32'(tok_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         e;
    int         k;
    logic [7:0] v;

    do_reset();

    // 3 4 add finish -> 7
    send_tok(1'b0, 8'd3, e, k, v);
    send_tok(1'b0, 8'd4, e, k, v);
    send_tok(1'b1, 8'b000, e, k, v);
    check("add_q_back", 32'(q_back), 32'd7);
    send_tok(1'b1, 8'b100, e, k, v);
    take_result(v, 0);

    // 2 5 sub -> 253, then 16 16 mul -> 0
    send_tok(1'b0, 8'd2, e, k, v);
    send_tok(1'b0, 8'd5, e, k, v);
    send_tok(1'b1, 8'b001, e, k, v);
    check("sub_q_back", 32'(q_back), 32'd253);
    send_tok(1'b1, 8'b100, e, k, v);
    take_result(v, 1);
    send_tok(1'b0, 8'd16, e, k, v);
    send_tok(1'b0, 8'd16, e, k, v);
    send_tok(1'b1, 8'b1111_0010, e, k, v);
    check("mul_q_back", 32'(q_back), 32'd0);
    send_tok(1'b1, 8'b100, e, k, v);
    take_result(v, 0);

    // operator with one operand: error, queue keeps 9; then finish with a stalled consumer
    send_tok(1'b0, 8'd9, e, k, v);
    send_tok(1'b1, 8'b000, e, k, v);
    check("underflow_err", 32'(e), 32'd1);
    clear_err();
    send_tok(1'b1, 8'b100, e, k, v);
    take_result(v, 5);

    // six operands: the sixth overflows and must not be pushed
    for (int i = 1; i <= 6; i++) send_tok(1'b0, 8'(i), e, k, v);
    check("overflow_depth", 32'(q_pos_back), 32'd5);
    clear_err();
    flush();

    // err_clr outside ERROR has no effect
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("idle_clr_busy", 32'(busy), 32'd0);
    check("idle_clr_err", 32'(err), 32'd0);

    // queue error while idle: no token taken, go to ERROR
    q_is_err = 1'b1;
    #1;
    check("qerr_tok_ready", 32'(tok_ready), 32'd0);
    @(negedge clk);
    check("qerr_idle_err", 32'(err), 32'd1);
    q_is_err = 1'b0;
    clear_err();

    // queue error reported in WAIT
    tok_valid = 1'b1; tok_is_op = 1'b0; tok_data = 8'h11;
    @(negedge clk);
    tok_valid = 1'b0; q_is_err = 1'b1;
    n_vec++;
    check("qerr_issue_qop", 32'(q_opcode), 32'd0);
    @(negedge clk);
    check("qerr_wait_noerr", 32'(err), 32'd0);
    @(negedge clk);
    check("qerr_wait_err", 32'(err), 32'd1);
    q_is_err = 1'b0;
    ref_q.push_back(8'h11);
    clear_err();
    flush();

    // async reset while a result is pending
    send_tok(1'b0, 8'd42, e, k, v);
    send_tok(1'b1, 8'b100, e, k, v);
    #2 rst = 1'b1;
    #1;
    check("arst_res_valid", 32'(res_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_qop", 32'(q_opcode), 32'd1);
    check("arst_tok_ready", 32'(tok_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_release_ready", 32'(tok_ready), 32'd1);
    check("arst_no_pop", 32'(q_pos_back), 32'd1);
    flush();

    // randomized token stream
    for (int it = 0; it < 200; it++) begin
      int         r, depth;
      bit         is_op;
      logic [7:0] d;
      depth = ref_q.size();
      r = $urandom_range(0, 9);
      if (r == 0) begin
        is_op = 1'($urandom); d = 8'($urandom);
      end else if (depth == 1 && r < 4) begin
        is_op = 1'b1; d = {5'($urandom), 1'b1, 2'($urandom)};
      end else if (depth >= 2 && (r < 6 || depth == 5)) begin
        is_op = 1'b1; d = {5'($urandom), 1'b0, 2'($urandom)};
      end else begin
        is_op = 1'b0; d = 8'($urandom);
      end
      send_tok(is_op, d, e, k, v);
      if (e) clear_err();
      else if (k == 2) take_result(v, $urandom_range(0, 3));
    end

    check("queue_never_misused", 32'(emu_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Controller that sequences the 5-entry operand queue and a small 8-bit ALU for the stack-calculator datapath.
- Accepts a token stream (operands, operators, finish) over valid/ready. Translates each token into one queue command (push, reduce-with-result, pop-front). Emits the final result over valid/ready.
- Sits between the token source (decoder/host) and the queue; the only block that drives queue opcode/data.

Parameters:
- W, 8, data width of operands, results and queue entries.
- DEPTH, 5, queue capacity; push is legal only while q_pos_back < DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- tok_valid  in  1  token offered
- tok_ready  out  1  token accepted when tok_valid&&tok_ready at posedge
- tok_is_op  in  1  0: operand, 1: operator/finish
- tok_data  in  W  operand value, or op code in [2:0] when tok_is_op
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_data  out  W  result value
- err  out  1  sticky protocol/capacity error
- err_clr  in  1  synchronous clear of err, returns FSM to IDLE
- busy  out  1  FSM not in IDLE
- q_opcode  out  2  queue command: 00 push, 10 reduce, 11 pop front, 01 idle
- q_back  out  W  data for push/reduce
- q_top_conc  in  2W  {entry0, entry1} from queue
- q_pos_back  in  3  queue occupancy
- q_is_err  in  1  queue error flag

Behaviour:
- Reset: state IDLE; tok_ready=0 while rst is asserted, then 1 in IDLE. res_valid=0, res_data=0, err=0, busy=0, q_opcode=01, q_back=0.
- States: IDLE, ISSUE, WAIT, EMIT, ERROR.
- IDLE: tok_ready=1. On accept, classify using the q_pos_back sampled that cycle (queue is idle, so the value is stable):
  - Operand (tok_is_op=0): if q_pos_back==DEPTH go to ERROR. Else latch q_back=tok_data, cmd=00, go to ISSUE.
  - Operator (tok_is_op=1, tok_data[2]=0): if q_pos_back<2 go to ERROR. Else a=q_top_conc[2W-1:W], b=q_top_conc[W-1:0]. Op [1:0]: 00 a+b, 01 a-b, 10 a*b low W bits, 11 a&b. All results are mod 2^W with no flags. Latch q_back=result, cmd=10, go to ISSUE.
  - Finish (tok_is_op=1, tok_data[2]=1): if q_pos_back!=1 go to ERROR. Else res_data=q_top_conc[2W-1:W], go to EMIT.
  - Tokens with tok_data[7:3]!=0 and tok_is_op=1 are still decoded on [2:0] only.
- ISSUE: q_opcode=cmd for exactly one cycle, then WAIT. tok_ready=0.
- WAIT: q_opcode=01. If q_is_err=1 go to ERROR, else IDLE. Token-to-token throughput is therefore 3 cycles.
- EMIT: res_valid=1; res_data held stable until handshake. On res_valid&&res_ready: res_valid=0 next cycle, cmd=11, go to ISSUE (pops the result; the queue becomes empty).
- ERROR: err=1 sticky, tok_ready=0, q_opcode=01, res_valid=0.
  - err_clr=1 → err=0 and state=IDLE next cycle. Queue contents are untouched, so software may continue or reset.
  - err_clr in a non-ERROR state: no effect.
- q_opcode is 01 in every state except ISSUE; the controller never issues an illegal command.
- busy = (state!=IDLE).
- Async rst in any state (including mid-ISSUE or EMIT): immediate return to reset values; any pending command and result are dropped.
- q_is_err is also checked in IDLE: if it is 1, go to ERROR without accepting a token.

Test Plan:
- rst, then tokens 3, 4, op add(000), finish(100) → reduce q_back=7; res_valid with res_data=7; after res_ready, pop issued, q_pos_back=0, err=0.
- Tokens 2, 5, op sub(001) → q_back=8'hFD (253). Then 16, 16, mul(010) → 0 (wrap).
- Single operand 9 then op add → err=1, tok_ready=0, q_opcode stays 01 and queue holds 9. err_clr → IDLE, tok_ready=1.
- Six operands 1..6 → first five pushed (q_pos_back=5); sixth → err=1, no push issued.
- Finish with depth 1 and res_ready held 0 for 5 cycles → res_valid=1, res_data stable, no pop. Pop occurs 1 cycle after res_ready=1.
- Assert rst during EMIT → res_valid=0, state IDLE, q_opcode=01 the same cycle (async).
